// File: rtl/conv2d_stream_if.sv
// Configuration, pixel-stream and result-stream bundle for conv2d_stream.
interface conv2d_stream_if #(
    parameter int N          = 16,
    parameter int KernelSize = 3,
    parameter int AccW       = 2*N + $clog2(KernelSize*KernelSize) + 1
);
    logic                                    start_i;
    logic [13:0]                             matrix_size_i;
    logic [5:0]                              stride_i;
    logic [KernelSize*KernelSize-1:0][N-1:0] weights_i;
    logic signed [AccW-1:0]                  bias_i;
    logic signed [N-1:0]                     data_i;
    logic                                    data_valid_i;
    logic                                    data_ready_o;
    logic signed [AccW-1:0]                  conv_o;
    logic                                    conv_valid_o;
    logic                                    conv_ready_i;
    logic                                    busy_o;
    logic                                    done_o;
    logic                                    err_o;

    modport slave (
        input  start_i, matrix_size_i, stride_i, weights_i, bias_i,
        input  data_i, data_valid_i, conv_ready_i,
        output data_ready_o, conv_o, conv_valid_o, busy_o, done_o, err_o
    );

    modport master (
        output start_i, matrix_size_i, stride_i, weights_i, bias_i,
        output data_i, data_valid_i, conv_ready_i,
        input  data_ready_o, conv_o, conv_valid_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/conv2d_stream.sv
// Streaming KxK 2-D convolution over a raster-order MxM image with runtime size and stride.
// Line buffers feed a sliding window; products and their sum form a two-stage output pipeline.
module conv2d_stream #(
    parameter int MaxMatrixSize = 28,
    parameter int KernelSize    = 3,
    parameter int N             = 16,
    parameter int AccW          = 2*N + $clog2(KernelSize*KernelSize) + 1
) (
    input logic            clk_i,
    input logic            rst_i,
    conv2d_stream_if.slave s
);
    localparam int KK = KernelSize * KernelSize;
    localparam int CW = (MaxMatrixSize > 1) ? $clog2(MaxMatrixSize) : 1;
    localparam int PW = 2 * N;
    localparam logic [CW-1:0] KM1 = CW'(KernelSize - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    function automatic logic signed [PW-1:0] mul_full(input logic signed [N-1:0] a,
                                                      input logic signed [N-1:0] b);
        logic signed [PW-1:0] ax;
        logic signed [PW-1:0] bx;
        ax = PW'(a);
        bx = PW'(b);
        return ax * bx;
    endfunction

    function automatic logic signed [AccW-1:0] ext_acc(input logic signed [PW-1:0] p);
        return AccW'(p);
    endfunction

    logic [1:0]             state_q;
    logic [CW-1:0]          m_last_q;
    logic [5:0]             s_last_q;
    logic signed [N-1:0]    w_q [KK];
    logic signed [AccW-1:0] bias_q;
    logic [CW-1:0]          row_q, col_q;
    logic [5:0]             rph_q, cph_q;
    logic                   done_q, err_q;

    logic signed [N-1:0]    lb_mem  [KernelSize-1][MaxMatrixSize];
    logic signed [N-1:0]    win_q   [KernelSize][KernelSize];
    logic signed [N-1:0]    win_nxt [KernelSize][KernelSize];
    logic signed [N-1:0]    col_pix [KernelSize];

    logic signed [PW-1:0]   prod_p0 [KK];
    logic                   vld_p0, vld_p1;
    logic signed [AccW-1:0] sum_p1;
    logic signed [AccW-1:0] sum_nxt;

    logic [14:0] m_ext, s_span;
    logic        cfg_ok, start_ok, start_bad;
    logic        stall, ready, fire, hit, drain_exit;

    assign m_ext  = {1'b0, s.matrix_size_i};
    assign s_span = 15'(s.stride_i) + 15'(KernelSize - 1);
    assign cfg_ok = (m_ext >= 15'(KernelSize)) && (m_ext <= 15'(MaxMatrixSize)) &&
                    (s.stride_i != 6'd0) && (s_span <= m_ext);

    assign start_ok  = (state_q == IDLE) && s.start_i && cfg_ok;
    assign start_bad = (state_q == IDLE) && s.start_i && !cfg_ok;

    assign stall = vld_p1 && !s.conv_ready_i;
    assign ready = (state_q == RUN) && !stall;
    assign fire  = ready && s.data_valid_i;
    // Window is complete and on the stride grid when both phase counters sit at zero.
    assign hit   = (row_q >= KM1) && (col_q >= KM1) && (rph_q == 6'd0) && (cph_q == 6'd0);
    assign drain_exit = (state_q == DRAIN) && !vld_p0 && (!vld_p1 || s.conv_ready_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            rph_q   <= '0;
            cph_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= drain_exit;
            err_q  <= start_bad;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q <= RUN;
                        row_q   <= '0;
                        col_q   <= '0;
                        rph_q   <= '0;
                        cph_q   <= '0;
                    end
                end
                RUN: begin
                    if (fire) begin
                        if (col_q == m_last_q) begin
                            col_q <= '0;
                            cph_q <= '0;
                            if (row_q == m_last_q) begin
                                row_q   <= '0;
                                rph_q   <= '0;
                                state_q <= DRAIN;
                            end else begin
                                row_q <= row_q + 1'b1;
                                if (row_q >= KM1)
                                    rph_q <= (rph_q == s_last_q) ? 6'd0 : rph_q + 6'd1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                            if (col_q >= KM1)
                                cph_q <= (cph_q == s_last_q) ? 6'd0 : cph_q + 6'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_exit)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (start_ok) begin
            m_last_q <= CW'(s.matrix_size_i - 14'd1);
            s_last_q <= s.stride_i - 6'd1;
            bias_q   <= s.bias_i;
            for (int i = 0; i < KK; i++)
                w_q[i] <= $signed(s.weights_i[i]);
        end
    end

    always_comb begin
        col_pix[0] = s.data_i;
        for (int j = 1; j < KernelSize; j++)
            col_pix[j] = lb_mem[j-1][col_q];
        for (int r = 0; r < KernelSize; r++) begin
            for (int c = 0; c < KernelSize - 1; c++)
                win_nxt[r][c] = win_q[r][c+1];
            win_nxt[r][KernelSize-1] = col_pix[KernelSize-1-r];
        end
    end

    always_ff @(posedge clk_i) begin
        if (fire) begin
            lb_mem[0][col_q] <= s.data_i;
            for (int j = KernelSize - 2; j >= 1; j--)
                lb_mem[j][col_q] <= lb_mem[j-1][col_q];
            win_q <= win_nxt;
        end
    end

    // Stage p0: products of the window as it stands after the accepted pixel.
    always_ff @(posedge clk_i) begin
        if (!stall) begin
            for (int r = 0; r < KernelSize; r++)
                for (int c = 0; c < KernelSize; c++)
                    prod_p0[r*KernelSize+c] <= mul_full(win_nxt[r][c], w_q[r*KernelSize+c]);
        end
    end

    always_comb begin
        sum_nxt = bias_q;
        for (int i = 0; i < KK; i++)
            sum_nxt = sum_nxt + ext_acc(prod_p0[i]);
    end

    // Stage p1: biased sum, held while the consumer stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            sum_p1 <= '0;
        end else if (!stall) begin
            vld_p0 <= fire && hit;
            vld_p1 <= vld_p0;
            if (vld_p0)
                sum_p1 <= sum_nxt;
        end
    end

    assign s.data_ready_o = ready;
    assign s.conv_o       = sum_p1;
    assign s.conv_valid_o = vld_p1;
    assign s.busy_o       = (state_q != IDLE);
    assign s.done_o       = done_q;
    assign s.err_o        = err_q;
endmodule

// File: tb/tb_conv2d_stream.sv
// Randomized bench for conv2d_stream: a direct window-sum model predicts every output,
// with literal ramp-image values pinning the model.
module tb_conv2d_stream;
    localparam int MaxM = 28;
    localparam int K    = 3;
    localparam int N    = 16;
    localparam int KK   = K * K;
    localparam int AccW = 2*N + $clog2(KK) + 1;

    typedef logic signed [AccW-1:0] acc_t;
    typedef acc_t acc_q_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv2d_stream_if #(.N(N), .KernelSize(K), .AccW(AccW)) bus ();

    conv2d_stream #(.MaxMatrixSize(MaxM), .KernelSize(K), .N(N), .AccW(AccW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .s     (bus)
    );

    int     checks = 0;
    int     errors = 0;
    int     img [MaxM*MaxM];
    int     w [KK];
    longint bias;
    acc_t   exp_q [$];
    acc_t   got_all [$];
    longint xfer_time [int];
    int     done_cnt = 0;
    int     err_cnt = 0;
    int     xfer_cnt = 0;
    int     stall_seen = 0;
    int     ready_mode = 0;
    int     stall_base = 0;
    logic   prev_stall = 1'b0;
    acc_t   prev_conv = '0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic acc_q_t model(input int M, input int S);
        acc_q_t q;
        int no;
        no = (M - K) / S + 1;
        for (int orow = 0; orow < no; orow++)
            for (int ocol = 0; ocol < no; ocol++) begin
                longint acc;
                acc = bias;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        acc += longint'(w[i*K+j]) * longint'(img[(orow*S+i)*M + ocol*S + j]);
                q.push_back(AccW'(acc));
            end
        return q;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            exp_q.delete();
        end else begin
            if (bus.done_o) begin
                done_cnt++;
                check("busy_low_at_done", bus.busy_o, 0);
            end
            if (bus.err_o) err_cnt++;
            if (!bus.busy_o) check("idle_ready_low", bus.data_ready_o, 0);
            if (prev_stall) begin
                check("stall_hold_valid", bus.conv_valid_o, 1);
                check("stall_hold_data", bus.conv_o, prev_conv);
            end
            if (bus.conv_valid_o && !bus.conv_ready_i) begin
                check("ready_low_in_stall", bus.data_ready_o, 0);
                if (ready_mode == 2) begin
                    stall_seen++;
                    check("stall_value", bus.conv_o, 117);
                end
            end
            if (bus.conv_valid_o && bus.conv_ready_i) begin
                xfer_time[xfer_cnt] = longint'($time);
                got_all.push_back(bus.conv_o);
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_output: got %0d with no output expected", bus.conv_o);
                end else begin
                    check("conv_value", bus.conv_o, exp_q.pop_front());
                end
            end
            prev_stall = bus.conv_valid_o && !bus.conv_ready_i;
            prev_conv  = bus.conv_o;
        end
    end

    initial begin : ready_gen
        int stalls;
        stalls = 0;
        bus.conv_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                stalls = 0;
                bus.conv_ready_i = 1'b1;
            end else if (ready_mode == 1) begin
                stalls = 0;
                bus.conv_ready_i = ($urandom_range(0, 99) < 70);
            end else if ((xfer_cnt - stall_base) == 4 && bus.conv_valid_o && stalls < 10) begin
                stalls++;
                bus.conv_ready_i = 1'b0;
            end else begin
                bus.conv_ready_i = 1'b1;
            end
        end
    end

    task automatic fill_ramp_ones();
        for (int i = 0; i < MaxM*MaxM; i++) img[i] = i;
        for (int i = 0; i < KK; i++) w[i] = 1;
        bias = 0;
    endtask

    task automatic fill_random(input bit extreme);
        logic signed [15:0]   v;
        logic [AccW-1:0]      b;
        for (int i = 0; i < MaxM*MaxM; i++) begin
            v = extreme ? 16'sh8000 : 16'($urandom);
            img[i] = v;
        end
        for (int i = 0; i < KK; i++) begin
            v = extreme ? 16'sh8000 : 16'($urandom);
            w[i] = v;
        end
        b = AccW'({$urandom, $urandom});
        bias = longint'($signed(b));
    endtask

    // Called right after a rising edge; ends on a rising edge (or after an aborting reset).
    task automatic run_frame(input int M, input int S, input bit rand_valid,
                             input int abort_after, input int mid_start_at, input bit chk_lat);
        acc_q_t q;
        int     idx, guard, cyc, done_base, err_base, xfer_base, lat_px;
        bit     mid_done;
        longint lat_time;
        #1;
        bus.matrix_size_i = 14'(M);
        bus.stride_i      = 6'(S);
        for (int i = 0; i < KK; i++) bus.weights_i[i] = 16'(w[i]);
        bus.bias_i = AccW'(bias);
        q = model(M, S);
        foreach (q[i]) exp_q.push_back(q[i]);
        done_base = done_cnt;
        err_base  = err_cnt;
        xfer_base = xfer_cnt;
        lat_px    = (K-1)*M + (K-1);
        lat_time  = -1;
        mid_done  = 1'b0;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        check("busy_after_start", bus.busy_o, 1);
        idx = 0;
        guard = 0;
        while (idx < M*M && guard < 20000) begin
            bus.data_valid_i = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.data_i = 16'(img[idx]);
            if (idx == mid_start_at && !mid_done) begin
                mid_done = 1'b1;
                bus.start_i = 1'b1;
                bus.matrix_size_i = 14'd5;
                bus.stride_i = 6'd0;
            end
            @(negedge clk);
            if (bus.data_valid_i && bus.data_ready_o) begin
                if (idx == lat_px) lat_time = longint'($time);
                idx++;
            end
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            guard++;
            if (abort_after > 0 && idx == abort_after) break;
        end
        bus.data_valid_i = 1'b0;
        if (guard >= 20000) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: accepted %0d of %0d pixels", idx, M*M);
        end
        if (abort_after > 0) begin
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            check("abort_busy", bus.busy_o, 0);
            check("abort_valid", bus.conv_valid_o, 0);
            check("abort_conv", bus.conv_o, 0);
            rst = 1'b0;
            repeat (5) @(posedge clk);
            check("abort_no_done", done_cnt - done_base, 0);
            return;
        end
        cyc = 0;
        while (done_cnt == done_base && cyc < 5000) begin
            @(posedge clk);
            cyc++;
        end
        if (done_cnt == done_base) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles", cyc);
        end
        check("out_count", xfer_cnt - xfer_base, ((M-K)/S + 1) * ((M-K)/S + 1));
        check("exp_left", exp_q.size(), 0);
        check("done_count", done_cnt - done_base, 1);
        check("err_count", err_cnt - err_base, 0);
        if (chk_lat) check("latency_ns", xfer_time[xfer_base] - lat_time, 20);
    endtask

    task automatic cfg_err(input int M, input int S);
        #1;
        bus.matrix_size_i = 14'(M);
        bus.stride_i = 6'(S);
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        check("err_pulse", bus.err_o, 1);
        check("err_busy", bus.busy_o, 0);
        check("err_ready", bus.data_ready_o, 0);
        @(negedge clk);
        check("err_single", bus.err_o, 0);
        check("err_busy_after", bus.busy_o, 0);
        @(posedge clk);
    endtask

    initial begin
        acc_q_t pin;
        int base, sbase;
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.matrix_size_i = '0;
        bus.stride_i = '0;
        bus.weights_i = '0;
        bus.bias_i = '0;
        bus.data_i = '0;
        bus.data_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_o, 0);
        check("rst_err", bus.err_o, 0);
        check("rst_valid", bus.conv_valid_o, 0);
        check("rst_ready", bus.data_ready_o, 0);
        check("rst_conv", bus.conv_o, 0);
        rst = 1'b0;

        fill_ramp_ones();
        pin = model(8, 1);
        check("model_s1_count", pin.size(), 36);
        check("model_s1_first", pin[0], 81);
        check("model_s1_mid", pin[10], 189);
        check("model_s1_last", pin[35], 486);
        pin = model(8, 2);
        check("model_s2_count", pin.size(), 9);
        check("model_s2_last", pin[8], 405);

        @(posedge clk);
        base = got_all.size();
        run_frame(8, 1, 1'b0, 0, -1, 1'b1);
        check("s1_first", got_all[base], 81);
        check("s1_last", got_all[got_all.size()-1], 486);

        base = got_all.size();
        run_frame(8, 2, 1'b0, 0, -1, 1'b0);
        check("s2_first", got_all[base], 81);
        check("s2_last", got_all[got_all.size()-1], 405);

        stall_base = xfer_cnt;
        sbase = stall_seen;
        ready_mode = 2;
        base = got_all.size();
        run_frame(8, 1, 1'b0, 0, -1, 1'b0);
        ready_mode = 0;
        check("stall_cycles", stall_seen - sbase, 10);
        check("stall_fifth", got_all[base+4], 117);

        base = got_all.size();
        run_frame(8, 1, 1'b1, 0, -1, 1'b0);
        check("rv_first", got_all[base], 81);
        check("rv_last", got_all[got_all.size()-1], 486);

        run_frame(8, 1, 1'b0, 0, 20, 1'b0);

        cfg_err(2, 1);
        cfg_err(8, 0);
        cfg_err(8, 7);
        cfg_err(29, 1);

        run_frame(8, 1, 1'b0, 30, -1, 1'b0);
        @(posedge clk);
        base = got_all.size();
        run_frame(8, 1, 1'b0, 0, -1, 1'b1);
        check("post_abort_first", got_all[base], 81);
        check("post_abort_last", got_all[got_all.size()-1], 486);

        ready_mode = 1;
        fill_random(1'b1);
        run_frame(5, 1, 1'b1, 0, -1, 1'b0);
        fill_random(1'b0);
        run_frame(3, 1, 1'b1, 0, -1, 1'b0);
        fill_random(1'b0);
        run_frame(8, 6, 1'b1, 0, -1, 1'b0);
        fill_random(1'b0);
        run_frame(28, 26, 1'b1, 0, -1, 1'b0);
        fill_random(1'b0);
        run_frame(28, 1, 1'b1, 0, -1, 1'b0);
        for (int t = 0; t < 6; t++) begin
            int m, st;
            m  = $urandom_range(3, 12);
            st = $urandom_range(1, m - 2);
            fill_random(1'b0);
            run_frame(m, st, 1'b1, 0, -1, 1'b0);
        end
        ready_mode = 0;

        base = done_cnt;
        repeat (10) @(posedge clk);
        check("no_late_done", done_cnt - base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit after %0d checks", checks);
        $fatal(1, "watchdog");
    end
endmodule
